clk_ratio_mon: RTL

//  Downstream checker for the divide-by-4.5 clock generator. It samples the divided

---
 rtl/clk_mon_pkg.sv | 16 +
 rtl/clk_mon_edge_sync.sv | 28 ++
 rtl/clk_ratio_mon.sv | 135 +++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clk_ratio_mon divided-clock checker.
//   state_t  : measurement FSM states
//   MIN_IVL / MAX_IVL : legal clk_in-cycle spacing between divided-clock edges
//                       (a /4.5 clock alternates 4 and 5)
//   in_tol() : signed-int window compare, safe when EXP_EDGES < TOL
package clk_mon_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  localparam int MIN_IVL = 4;
  localparam int MAX_IVL = 5;
  localparam int IVL_W   = 4;

  function automatic logic in_tol(input int cnt, input int exp_v, input int tol);
    return (cnt >= exp_v - tol) && (cnt <= exp_v + tol);
  endfunction
endpackage

// File: rtl/clk_mon_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous clock
// that is sampled as data.
//   i_clk   : sampling clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input (divided clock)
//   o_rise  : one-cycle pulse, consumed on the 3rd sampling edge after i_d rises
module clk_mon_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic r_meta, r_sync, r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/clk_ratio_mon.sv
// Divided-clock ratio checker: counts clk_div rising edges over a fixed
// clk_in window after a settle period and flags pass/fail against the
// expected count.
//   clk_in, reset_n : clock, asynchronous active-low reset
//   start, abort    : begin measurement (IDLE only) / return to IDLE
//   clk_div         : divided clock under test (asynchronous)
//   busy            : SETTLE/MEASURE/REPORT
//   done            : one-cycle pulse, result valid
//   pass, edge_count: result, held until next accepted start
//   period_err      : interval violation (only with CLK_MON_PERIOD_CHK_EN,
//                     otherwise tied 0)
// Optional feature macro: CLK_MON_PERIOD_CHK_EN
module clk_ratio_mon
  import clk_mon_pkg::*;
#(
  parameter int WINDOW_CYC = 90,
  parameter int EXP_EDGES  = 20,
  parameter int TOL        = 1,
  parameter int SETTLE_CYC = 9,
  parameter int CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             clk_div,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] edge_count,
  output logic             period_err
);
  localparam int TMAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [TW-1:0]    r_tmr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_done, r_pass;
  logic             w_rise, w_accept, w_meas_edge, w_perr;

  clk_mon_edge_sync u_sync (
    .i_clk   (clk_in),
    .i_rst_n (reset_n),
    .i_d     (clk_div),
    .o_rise  (w_rise)
  );

  assign w_accept    = (r_state == IDLE) && start && !abort;
  // An abort cycle leaves results untouched, so its edge is not counted.
  assign w_meas_edge = (r_state == MEASURE) && w_rise && !abort;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_tmr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_meas_edge && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_state <= SETTLE;
            r_busy  <= 1'b1;
            r_tmr   <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
          end
          SETTLE: if (r_tmr == TW'(SETTLE_CYC - 1)) begin
            r_state <= MEASURE;
            r_tmr   <= '0;
          end else r_tmr <= r_tmr + 1'b1;
          MEASURE: if (r_tmr == TW'(WINDOW_CYC - 1)) r_state <= REPORT;
                   else r_tmr <= r_tmr + 1'b1;
          REPORT: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= in_tol(int'(r_cnt), EXP_EDGES, TOL) && !w_perr;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CLK_MON_PERIOD_CHK_EN
  // r_ivl counts clk_in cycles since the last MEASURE edge; the first edge
  // of a window only arms the check.
  logic [IVL_W-1:0] r_ivl;
  logic             r_armed, r_perr;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_ivl   <= '0;
      r_armed <= 1'b0;
      r_perr  <= 1'b0;
    end else if (w_accept) begin
      r_ivl   <= '0;
      r_armed <= 1'b0;
      r_perr  <= 1'b0;
    end else if (r_state == MEASURE && !abort) begin
      if (w_rise) begin
        if (r_armed && (int'(r_ivl) < MIN_IVL || int'(r_ivl) > MAX_IVL))
          r_perr <= 1'b1;
        r_armed <= 1'b1;
        r_ivl   <= IVL_W'(1);
      end else if (r_ivl != '1) begin
        r_ivl <= r_ivl + 1'b1;
      end
    end
  end

  assign w_perr = r_perr;
`else
  assign w_perr = 1'b0;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign edge_count = r_cnt;
  assign period_err = w_perr;
endmodule
